pong_paddle_ctrl: RTL and testbench
===================================

// Module: pong_paddle_ctrl
// PURPOSE
//   Game-level sequencer for the two paddle instances of the pong datapath.
//   - Synchronises and debounces four raw player buttons plus START.
//   - Runs the IDLE/SERVE/PLAY/POINT game FSM.
//   - Issues exactly-one-cycle move strobes per video frame to each paddle, plus the paddle recentre (pad_reset).
// PARAMETERS
//   DEB_CYCLES     250000  clk cycles a raw input must hold stable before its debounced value changes (5 ms @ 50 MHz)
//   REPEAT_FRAMES  2       frame ticks between successive strobes while a button stays held (>=1)
//   SERVE_FRAMES   60      frame ticks spent in SERVE before PLAY (>=1)
// PORTS
//   clk           in   1  system clock
//   reset_n       in   1  asynchronous reset, active low
//   frame_tick    in   1  one-cycle pulse per frame (vsync start), synchronous to clk
//   btn_up        in   2  raw up buttons, bit0 = player 0, bit1 = player 1
//   btn_down      in   2  raw down buttons, same indexing
//   start         in   1  raw start button
//   point_scored  in   1  one-cycle pulse from ball logic, synchronous to clk
//   pad_up        out  2  one-cycle move-up strobe per paddle
//   pad_down      out  2  one-cycle move-down strobe per paddle
//   pad_reset     out  1  paddle recentre request (drives paddle reset)
//   serve_go      out  1  one-cycle pulse on the SERVE->PLAY transition (ball launch)
//   game_state    out  2  current FSM state encoding
// BEHAVIOUR
//   - Reset (asynchronous, reset_n=0):
//     - FSM -> IDLE; pad_up = pad_down = 0; serve_go = 0; pad_reset = 1.
//     - All counters clear; debounced values clear to 0.
//   - Input conditioning: each raw input passes a 2-flop synchroniser, then a debouncer.
//     - The debouncer counts cycles while the synchronised value differs from the debounced value; the count clears whenever the two match.
//     - The debounced value flips when the count reaches DEB_CYCLES-1.
//   - FSM (registered state; all outputs registered):
//     - IDLE: pad_reset = 1. Rising edge of debounced start -> SERVE.
//     - SERVE:
//       - pad_reset = 1 in the first SERVE cycle only; movement strobes are suppressed.
//       - Counts frame_ticks; on tick number SERVE_FRAMES -> PLAY, with serve_go = 1 for that single cycle.
//     - PLAY: movement strobes are enabled. point_scored -> POINT.
//     - POINT: pad_reset = 1 for one cycle; the next cycle -> SERVE.
//     - start is ignored outside IDLE.
//   - Movement, per player p, evaluated only on a frame_tick cycle while in PLAY:
//     - Direction: up_d[p] XOR down_d[p] selects the direction. Both pressed or neither pressed -> no strobe.
//     - Repeat counter rcnt[p]:
//       - Counts ticks modulo REPEAT_FRAMES while the same direction is held.
//       - Clears on release, on a direction change, and outside PLAY.
//     - A strobe fires when rcnt[p] == 0. The first tick after a press therefore always moves.
//     - Latency: the strobe is asserted the cycle after the frame_tick cycle and lasts exactly 1 cycle.
//     - pad_up[p] and pad_down[p] are never high together.
//   - Simultaneous events:
//     - point_scored together with frame_tick in PLAY: POINT wins, no strobe, and the repeat counters clear.
//     - frame_tick on the SERVE->PLAY cycle: counts toward SERVE only; the first strobe can come on the next tick.
//   - Widths: the debounce counter is $clog2(DEB_CYCLES) bits, the repeat counter $clog2(REPEAT_FRAMES+1) bits, and the serve counter $clog2(SERVE_FRAMES+1) bits. No counter wraps; each saturates or clears as stated above.
// STRUCTURE
//   - Shared package pong_pkg:
//     - game_state encoding: IDLE=2'd0, SERVE=2'd1, PLAY=2'd2, POINT=2'd3.
//     - PLAYERS = 2.
//     - Default timing constants DEB_CYCLES_DEF, SERVE_FRAMES_DEF.
//   - Sub-module btn_debounce (synchroniser + debouncer, parameter DEB_CYCLES) is instantiated 5 times.
//   - The FSM, repeat counters and strobe generation live in this module.
// TESTING (sim with DEB_CYCLES=4, REPEAT_FRAMES=2, SERVE_FRAMES=3)
//   1. Reset then idle: reset_n low for 3 cycles mid-PLAY
//      -> game_state=0, pad_reset=1, pad_up=pad_down=0 immediately (asynchronous), and they stay so after release.
//   2. start held for 10 cycles
//      -> SERVE with one cycle of pad_reset; after 3 frame_ticks, serve_go pulses once and game_state=2.
//   3. PLAY, btn_up[0] held across 5 frame_ticks
//      -> pad_up[0] pulses on ticks 1, 3 and 5, each 1 cycle long, 1 cycle after its tick; pad_up[1]=0.
//   4. PLAY, btn_up[1] and btn_down[1] both held for 4 ticks
//      -> no strobes. Release down -> pad_up[1] on the next tick.
//   5. Bounce: btn_down[0] toggles every 2 cycles for 20 cycles, then stays high
//      -> no strobe until the input has been stable for 4 cycles plus the synchroniser delay, then the next tick strobes.
//   6. PLAY, point_scored coincident with frame_tick while btn_up[0] is held
//      -> no strobe, game_state=3 for 1 cycle with pad_reset=1, then SERVE; start pulses during SERVE are ignored.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared types and default timing constants for the pong paddle
//             sequencer and its input conditioning.
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

    // Game FSM encoding, visible on the game_state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_POINT = 2'd3
    } game_state_t;

    // Held direction of one player's buttons; {up, down} one-hot or none
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10
    } dir_t;

    localparam int PLAYERS           = 2;
    localparam int DEB_CYCLES_DEF    = 250000;
    localparam int REPEAT_FRAMES_DEF = 2;
    localparam int SERVE_FRAMES_DEF  = 60;

    // Both or neither button pressed means no movement
    function automatic dir_t dir_of(input logic up, input logic dn);
        if (up && !dn) return DIR_UP;
        if (dn && !up) return DIR_DOWN;
        return DIR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser followed by a stability-count debouncer.
//             The output follows the input only after it has differed from
//             the current debounced value for DEB_CYCLES consecutive cycles.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db
);

    localparam int            CW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count cycles of disagreement; flip the debounced value at the last count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 != r_db) begin
            if (r_cnt == C_LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/pong_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_paddle_ctrl
//  Purpose  : Game-level sequencer for the two paddles: debounces the player
//             and start buttons, runs the IDLE/SERVE/PLAY/POINT FSM and emits
//             one-cycle move strobes per frame plus the paddle recentre.
//  Revision : 1.0  initial release
// ============================================================================
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int REPEAT_FRAMES = REPEAT_FRAMES_DEF,
    parameter int SERVE_FRAMES  = SERVE_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic [PLAYERS-1:0] btn_up,
    input  logic [PLAYERS-1:0] btn_down,
    input  logic               start,
    input  logic               point_scored,
    output logic [PLAYERS-1:0] pad_up,
    output logic [PLAYERS-1:0] pad_down,
    output logic               pad_reset,
    output logic               serve_go,
    output logic [1:0]         game_state
);

    localparam int            RW          = $clog2(REPEAT_FRAMES + 1);
    localparam int            SW          = $clog2(SERVE_FRAMES + 1);
    localparam logic [RW-1:0] C_REP_LAST  = RW'(REPEAT_FRAMES - 1);
    localparam logic [SW-1:0] C_SERV_LAST = SW'(SERVE_FRAMES - 1);
    localparam int            NUM_IN      = 2 * PLAYERS + 1;

    // Raw inputs packed as {start, down[1:0], up[1:0]}
    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_db;

    assign w_raw = {start, btn_down, btn_up};

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (w_raw[i]),
                .db      (w_db[i])
            );
        end
    endgenerate

    game_state_t                    r_state;
    game_state_t                    w_state_next;
    logic [SW-1:0]                  r_serve_cnt;
    logic [SW-1:0]                  w_serve_cnt_next;
    logic                           r_start_prev;
    logic                           w_start_rise;
    logic [PLAYERS-1:0][RW-1:0]     r_rcnt;
    logic [PLAYERS-1:0][RW-1:0]     w_rcnt_next;
    logic [PLAYERS-1:0][RW-1:0]     w_eff;
    logic [PLAYERS-1:0][1:0]        r_dir;
    logic [PLAYERS-1:0][1:0]        w_dir;
    logic [PLAYERS-1:0][1:0]        w_dir_next;
    logic [PLAYERS-1:0]             r_pad_up;
    logic [PLAYERS-1:0]             r_pad_down;
    logic [PLAYERS-1:0]             w_up_next;
    logic [PLAYERS-1:0]             w_dn_next;
    logic                           r_pad_reset;
    logic                           w_reset_next;
    logic                           r_serve_go;
    logic                           w_go_next;
    logic                           w_play_move;

    assign w_start_rise = w_db[NUM_IN-1] & ~r_start_prev;
    assign w_play_move  = (r_state == ST_PLAY) && !point_scored;

    // A direction change (including release) restarts the repeat count at 0
    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_dir
            assign w_dir[p] = dir_of(w_db[p], w_db[PLAYERS + p]);
            assign w_eff[p] = (w_dir[p] != r_dir[p]) ? '0 : r_rcnt[p];
        end
    endgenerate

    // Registered state, counters and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_serve_cnt  <= '0;
            r_start_prev <= 1'b0;
            r_rcnt       <= '0;
            r_dir        <= '0;
            r_pad_up     <= '0;
            r_pad_down   <= '0;
            r_pad_reset  <= 1'b1;
            r_serve_go   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_serve_cnt  <= w_serve_cnt_next;
            r_start_prev <= w_db[NUM_IN-1];
            r_rcnt       <= w_rcnt_next;
            r_dir        <= w_dir_next;
            r_pad_up     <= w_up_next;
            r_pad_down   <= w_dn_next;
            r_pad_reset  <= w_reset_next;
            r_serve_go   <= w_go_next;
        end
    end

    // Next-state, serve counting, repeat counters and strobe decode
    always_comb begin
        w_state_next     = r_state;
        w_serve_cnt_next = '0;
        w_go_next        = 1'b0;
        w_up_next        = '0;
        w_dn_next        = '0;
        w_rcnt_next      = '0;
        w_dir_next       = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) w_state_next = ST_SERVE;
            end
            ST_SERVE: begin
                w_serve_cnt_next = r_serve_cnt;
                if (frame_tick) begin
                    if (r_serve_cnt == C_SERV_LAST) begin
                        w_state_next     = ST_PLAY;
                        w_serve_cnt_next = '0;
                        w_go_next        = 1'b1;
                    end else begin
                        w_serve_cnt_next = r_serve_cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (point_scored) w_state_next = ST_POINT;
            end
            ST_POINT: begin
                w_state_next = ST_SERVE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A point on the same cycle as a tick suppresses the strobe
        if (w_play_move) begin
            for (int p = 0; p < PLAYERS; p++) begin
                w_dir_next[p]  = w_dir[p];
                w_rcnt_next[p] = w_eff[p];
                if (frame_tick && (w_dir[p] != DIR_NONE)) begin
                    if (w_eff[p] == '0) begin
                        if (w_dir[p] == DIR_UP) w_up_next[p] = 1'b1;
                        else                    w_dn_next[p] = 1'b1;
                    end
                    w_rcnt_next[p] = (w_eff[p] == C_REP_LAST) ? '0 : w_eff[p] + 1'b1;
                end
            end
        end

        // Recentre while idle, while in POINT, and on the first SERVE cycle
        w_reset_next = (w_state_next == ST_IDLE) || (w_state_next == ST_POINT) ||
                       ((w_state_next == ST_SERVE) && (r_state != ST_SERVE));
    end

    assign pad_up     = r_pad_up;
    assign pad_down   = r_pad_down;
    assign pad_reset  = r_pad_reset;
    assign serve_go   = r_serve_go;
    assign game_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_paddle_ctrl
//  Purpose  : Self-checking bench for pong_paddle_ctrl with a behavioural
//             reference model and an expected-output scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_paddle_ctrl;

    localparam int DEB = 4;
    localparam int REP = 2;
    localparam int SRV = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic [1:0] btn_up;
    logic [1:0] btn_down;
    logic       start;
    logic       point_scored;
    logic [1:0] pad_up;
    logic [1:0] pad_down;
    logic       pad_reset;
    logic       serve_go;
    logic [1:0] game_state;

    pong_paddle_ctrl #(
        .DEB_CYCLES    (DEB),
        .REPEAT_FRAMES (REP),
        .SERVE_FRAMES  (SRV)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .start        (start),
        .point_scored (point_scored),
        .pad_up       (pad_up),
        .pad_down     (pad_down),
        .pad_reset    (pad_reset),
        .serve_go     (serve_go),
        .game_state   (game_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got=%0h want=%0h @%0t", name, got, want, $time);
    endtask

    // ---------------- reference model (behavioural) ----------------
    int         m_st, m_cyc, m_srv;
    logic [4:0] m_s1, m_s2, m_db;
    int         m_run [5];
    logic       m_sprev;
    logic [1:0] m_hold [2];
    int         m_n [2];
    logic [1:0] m_up, m_dn;

    function automatic void model_reset();
        m_st = 0; m_cyc = 0; m_srv = 0;
        m_s1 = '0; m_s2 = '0; m_db = '0; m_sprev = 1'b0;
        m_up = '0; m_dn = '0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        for (int p = 0; p < 2; p++) begin m_hold[p] = 2'b00; m_n[p] = 0; end
    endfunction

    function automatic void model_clock();
        logic [4:0] raw;
        logic [1:0] d;
        int         nst;
        if (!reset_n) begin model_reset(); return; end
        raw  = {start, btn_down, btn_up};
        m_up = '0; m_dn = '0;
        nst  = m_st;
        case (m_st)
            0: if (m_db[4] && !m_sprev) nst = 1;
            1: if (frame_tick) begin m_srv++; if (m_srv == SRV) nst = 2; end
            2: if (point_scored) nst = 3;
            default: nst = 1;
        endcase
        for (int p = 0; p < 2; p++) begin
            d = (m_db[p] != m_db[2+p]) ? {m_db[p], m_db[2+p]} : 2'b00;
            if (m_st == 2 && !point_scored) begin
                if (d != m_hold[p]) begin m_hold[p] = d; m_n[p] = 0; end
                if (frame_tick && d != 2'b00) begin
                    if (m_n[p] % REP == 0) begin
                        if (d[1]) m_up[p] = 1'b1; else m_dn[p] = 1'b1;
                    end
                    m_n[p]++;
                end
            end else begin
                m_hold[p] = 2'b00; m_n[p] = 0;
            end
        end
        m_cyc = (nst != m_st) ? 0 : m_cyc + 1;
        if (nst != 1) m_srv = 0;
        m_st    = nst;
        m_sprev = m_db[4];
        // debounced value follows once the synchronised input disagreed DEB cycles in a row
        for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endfunction

    function automatic logic [7:0] exp_vec();
        logic prst, go;
        prst = (m_st == 0) || (m_st == 3) || (m_st == 1 && m_cyc == 0);
        go   = (m_st == 2) && (m_cyc == 0);
        return {2'(m_st), prst, go, m_up, m_dn};
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [7:0] exp_q [$];
    int p_up0 = 0, p_up1 = 0, p_dn0 = 0, p_dn1 = 0, p_go = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        p_up0 += int'(pad_up[0]);   p_up1 += int'(pad_up[1]);
        p_dn0 += int'(pad_down[0]); p_dn1 += int'(pad_down[1]);
        p_go  += int'(serve_go);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{state,rst,go,up,dn}", {game_state, pad_reset, serve_go, pad_up, pad_down}, e);
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] up_v = '0, dn_v = '0;
    logic       start_v = 1'b0, rst_v = 1'b0;
    int         phase = 0;
    bit         rand_tick = 1'b0;

    task automatic step(input logic pnt);
        @(posedge clk);
        model_clock();
        #1;
        reset_n      = rst_v;
        btn_up       = up_v;
        btn_down     = dn_v;
        start        = start_v;
        point_scored = pnt;
        if (rand_tick) frame_tick = ($urandom_range(0, 3) == 0);
        else begin frame_tick = (phase == 0); phase = (phase + 1) % 5; end
        if (!rst_v) model_reset();
        exp_q.push_back(exp_vec());
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        for (int k = 0; k < budget && m_st != s; k++) step(1'b0);
        check(nm, 32'(game_state), 32'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        reset_n = 1'b0; btn_up = '0; btn_down = '0; start = 1'b0;
        frame_tick = 1'b0; point_scored = 1'b0;
        model_reset();
        run(3);
        rst_v = 1'b1;
        run(5);
        check("reset_state", 32'(game_state), 32'd0);
        check("reset_pad_reset", 32'(pad_reset), 32'd1);

        // start held -> SERVE -> PLAY with a single serve_go
        start_v = 1'b1; run(10); start_v = 1'b0;
        s0 = p_go;
        wait_state(2, 100, "t2_reach_play");
        settle();
        check("t2_serve_go_count", 32'(p_go - s0), 32'd1);

        // up0 held across exactly 5 ticks -> strobes on ticks 1,3,5
        for (int k = 0; k < 10 && phase != 1; k++) step(1'b0);
        s0 = p_up0; s1 = p_up1 + p_dn0 + p_dn1;
        up_v = 2'b01; run(28); up_v = 2'b00; run(10);
        settle();
        check("t3_up0_pulses", 32'(p_up0 - s0), 32'd3);
        check("t3_other_pulses", 32'(p_up1 + p_dn0 + p_dn1 - s1), 32'd0);

        // both buttons of player 1 -> nothing; release down -> one up strobe
        s0 = p_up1 + p_dn1;
        up_v = 2'b10; dn_v = 2'b10; run(25);
        settle();
        check("t4_both_held", 32'(p_up1 + p_dn1 - s0), 32'd0);
        s0 = p_up1;
        dn_v = 2'b00; run(15);
        settle();
        check("t4_after_release", 32'(p_up1 - s0), 32'd1);
        up_v = 2'b00; run(10);

        // bouncing down0 never debounces; stable high then strobes once
        s0 = p_dn0;
        for (int k = 0; k < 10; k++) begin dn_v[0] = ~dn_v[0]; run(2); end
        settle();
        check("t5_bounce_quiet", 32'(p_dn0 - s0), 32'd0);
        s0 = p_dn0;
        dn_v = 2'b01; run(12);
        settle();
        check("t5_stable_strobe", 32'(p_dn0 - s0), 32'd1);
        dn_v = 2'b00; run(10);

        // point coincident with tick while up0 held
        up_v = 2'b01; run(10);
        for (int k = 0; k < 10 && phase != 0; k++) step(1'b0);
        s0 = p_up0;
        step(1'b1);
        step(1'b0);
        check("t6_point_state", 32'(game_state), 32'd3);
        check("t6_point_pad_reset", 32'(pad_reset), 32'd1);
        step(1'b0);
        check("t6_serve_state", 32'(game_state), 32'd1);
        check("t6_no_strobe", 32'(p_up0 - s0), 32'd0);
        start_v = 1'b1; run(6); start_v = 1'b0;
        check("t6_start_ignored", 32'(game_state), 32'd1);
        up_v = 2'b00;
        wait_state(2, 60, "t6_back_to_play");

        // asynchronous reset mid-PLAY
        up_v = 2'b10; run(12);
        rst_v = 1'b0; step(1'b0); #1;
        check("t1_async_state", 32'(game_state), 32'd0);
        check("t1_async_pad_reset", 32'(pad_reset), 32'd1);
        check("t1_async_strobes", 32'({pad_up, pad_down}), 32'd0);
        run(2); rst_v = 1'b1; up_v = 2'b00; run(3);
        check("t1_after_release_state", 32'(game_state), 32'd0);
        check("t1_after_release_pad_reset", 32'(pad_reset), 32'd1);

        // randomized traffic against the model
        rand_tick = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) up_v = 2'($urandom);
            if ($urandom_range(0, 9) == 0) dn_v = 2'($urandom);
            if ($urandom_range(0, 19) == 0) start_v = ~start_v;
            rst_v = ($urandom_range(0, 599) != 0);
            step($urandom_range(0, 29) == 0);
        end
        rst_v = 1'b1;
        run(2);
        settle();
        settle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
